// File: rtl/range_tree_loader.sv
// ============================================================================
//  Module      : range_tree_loader
//  Description : Loads a 15-node balanced range-lookup tree from a word
//                stream. The first 15 words are boundaries, which arrive in
//                ascending in-order sequence and are scattered to BFS node
//                addresses. The next 16 words are rule-ID sets, which are
//                written to leaf addresses 0..15. Each write to a memory is
//                registered and lasts one cycle.
//
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                start             - one-cycle pulse that begins a load
//                in_valid/in_data  - upstream word stream
//                in_ready          - a word is accepted when in_valid && in_ready
//                bound_we/addr/din - boundary memory write port (BFS node 0..14)
//                rids_we/addr/din  - RIDS memory write port (leaf 0..15)
//                busy              - a load is in progress; the lookup tree is stalled
//                done              - one-cycle pulse after a successful load
//                err               - sticky flag for a boundary ordering error
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module range_tree_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int RIDS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  bound_we,
    output logic [3:0]            bound_addr,
    output logic [DATA_WIDTH-1:0] bound_din,
    output logic                  rids_we,
    output logic [3:0]            rids_addr,
    output logic [RIDS_WIDTH-1:0] rids_din,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [3:0] c_LAST_BOUND_IDX = 4'd14;
    localparam logic [3:0] c_LAST_RIDS_IDX  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_BOUND = 3'd1,
        S_LOAD_RIDS  = 3'd2,
        S_FINISH     = 3'd3,
        S_ERROR      = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    // One index is shared by both phases: in-order boundary index, then leaf index.
    logic [3:0]              r_idx;
    logic [DATA_WIDTH-1:0]   r_prev;
    logic                    r_err;
    logic                    r_done;
    logic                    r_bound_we;
    logic [3:0]              r_bound_addr;
    logic [DATA_WIDTH-1:0]   r_bound_din;
    logic                    r_rids_we;
    logic [3:0]              r_rids_addr;
    logic [RIDS_WIDTH-1:0]   r_rids_din;

    logic                    w_accept;
    logic                    w_order_err;
    logic                    w_bound_wr;
    logic                    w_rids_wr;
    logic                    w_clear;
    logic [RIDS_WIDTH-1:0]   w_rids_word;

    // Adapt the stream word to the RIDS width: truncate or zero-extend it.
    generate
        if (RIDS_WIDTH <= DATA_WIDTH) begin : g_rids_trunc
            assign w_rids_word = in_data[RIDS_WIDTH-1:0];
        end else begin : g_rids_ext
            assign w_rids_word = {{(RIDS_WIDTH-DATA_WIDTH){1'b0}}, in_data};
        end
    endgenerate

    // Maps an in-order index i to a BFS node. With k = i+1, the number of
    // trailing zeros of k selects the tree level. The root is at level 0 and
    // has tz = 3. The position inside the level is k >> (tz+1).
    function automatic logic [3:0] f_bfs_node(input logic [3:0] i);
        logic [3:0] k;
        logic [3:0] node;
        k = i + 4'd1;
        if (k[0])
            node = 4'd7 + {1'b0, k[3:1]};
        else if (k[1])
            node = 4'd3 + {2'b00, k[3:2]};
        else if (k[2])
            node = 4'd1 + {3'b000, k[3]};
        else
            node = 4'd0;
        return node;
    endfunction

    assign in_ready = (r_state == S_LOAD_BOUND) || (r_state == S_LOAD_RIDS);
    assign busy     = (r_state == S_LOAD_BOUND) || (r_state == S_LOAD_RIDS) ||
                      (r_state == S_FINISH);
    assign w_accept = in_valid && in_ready;

    assign bound_we   = r_bound_we;
    assign bound_addr = r_bound_addr;
    assign bound_din  = r_bound_din;
    assign rids_we    = r_rids_we;
    assign rids_addr  = r_rids_addr;
    assign rids_din   = r_rids_din;
    assign done       = r_done;
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_order_err  = 1'b0;
        w_bound_wr   = 1'b0;
        w_rids_wr    = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = S_LOAD_BOUND;
                end
            end
            S_LOAD_BOUND: begin
                if (w_accept) begin
                    // The first boundary has no predecessor to compare with.
                    if ((r_idx != 4'd0) && (in_data <= r_prev)) begin
                        w_order_err  = 1'b1;
                        w_state_next = S_ERROR;
                    end else begin
                        w_bound_wr = 1'b1;
                        if (r_idx == c_LAST_BOUND_IDX)
                            w_state_next = S_LOAD_RIDS;
                    end
                end
            end
            S_LOAD_RIDS: begin
                if (w_accept) begin
                    w_rids_wr = 1'b1;
                    if (r_idx == c_LAST_RIDS_IDX)
                        w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= 4'd0;
            r_prev       <= '0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_bound_we   <= 1'b0;
            r_bound_addr <= 4'd0;
            r_bound_din  <= '0;
            r_rids_we    <= 1'b0;
            r_rids_addr  <= 4'd0;
            r_rids_din   <= '0;
        end else begin
            r_bound_we <= w_bound_wr;
            r_rids_we  <= w_rids_wr;
            // FINISH lasts one cycle, so done rises one cycle after the last write.
            r_done     <= (r_state == S_FINISH);

            if (w_clear) begin
                r_idx  <= 4'd0;
                r_prev <= '0;
                r_err  <= 1'b0;
            end

            if (w_order_err)
                r_err <= 1'b1;

            if (w_bound_wr) begin
                r_bound_addr <= f_bfs_node(r_idx);
                r_bound_din  <= in_data;
                r_prev       <= in_data;
                r_idx        <= (r_idx == c_LAST_BOUND_IDX) ? 4'd0 : r_idx + 4'd1;
            end

            if (w_rids_wr) begin
                r_rids_addr <= r_idx;
                r_rids_din  <= w_rids_word;
                r_idx       <= r_idx + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire
